// File: rtl/rom_pkg.sv
// Shared constants and load-FSM state type for the ROM loader and its storage.
package rom_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 3;
  localparam int DEPTH  = 8;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DONE
  } load_state_e;

endpackage

// File: rtl/rom_store.sv
// DEPTH x DATA_W storage with a synchronous write port and a registered,
// read-before-write read port that returns 0 when not enabled.
module rom_store #(
  parameter int DATA_W = rom_pkg::DATA_W,
  parameter int ADDR_W = rom_pkg::ADDR_W,
  parameter int DEPTH  = rom_pkg::DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              enb,
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] out
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] out_q;

  // Write port: store the accepted byte at the write pointer.
  // NOTE: the array is deliberately left out of reset so it maps onto plain
  // RAM/LUT storage and keeps its contents across a reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Read port: register the addressed word, or 0 when disabled.
  // NOTE: non-blocking assignments make every flop sample pre-edge values, so
  // a same-address read and write in one cycle returns the old word.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_q <= '0;
    end else if (enb) begin
      out_q <= mem_q[addr];
    end else begin
      out_q <= '0;
    end
  end

  assign out = out_q;

endmodule

// File: rtl/rom_loader.sv
// Loads DEPTH bytes over valid/ready into rom_store in address order, reports
// an XOR checksum and a byte count, and pulses done once per completed load.
module rom_loader
  import rom_pkg::load_state_e;
  import rom_pkg::IDLE;
  import rom_pkg::LOAD;
  import rom_pkg::DONE;
#(
  parameter int DATA_W = rom_pkg::DATA_W,
  parameter int ADDR_W = rom_pkg::ADDR_W,
  parameter int DEPTH  = rom_pkg::DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] checksum,
  output logic [ADDR_W:0]   wr_count,
  input  logic              enb,
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] out
);

  load_state_e       state_q,    state_d;
  logic [ADDR_W-1:0] wr_ptr_q,   wr_ptr_d;
  logic [ADDR_W:0]   wr_count_q, wr_count_d;
  logic [DATA_W-1:0] checksum_q, checksum_d;
  logic              we;

  // Next-state, datapath updates and state-decoded handshake outputs.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no branch can
    // leave one unassigned and infer a latch.
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    wr_count_d = wr_count_q;
    checksum_d = checksum_q;
    in_ready   = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    we         = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = LOAD;
          wr_ptr_d   = '0;
          wr_count_d = '0;
          checksum_d = '0;
        end
      end
      LOAD: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid) begin
          we         = 1'b1;
          wr_ptr_d   = wr_ptr_q + 1'b1;
          wr_count_d = wr_count_q + 1'b1;
          checksum_d = checksum_q ^ in_data;
          if (wr_ptr_q == ADDR_W'(DEPTH - 1)) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, pointer, count and checksum registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      wr_count_q <= '0;
      checksum_q <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      wr_count_q <= wr_count_d;
      checksum_q <= checksum_d;
    end
  end

  assign checksum = checksum_q;
  assign wr_count = wr_count_q;

  rom_store #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_store (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (we),
    .waddr (wr_ptr_q),
    .wdata (in_data),
    .enb   (enb),
    .addr  (addr),
    .out   (out)
  );

endmodule

// File: tb/tb_rom_loader.sv
// Self-checking bench for rom_loader: directed loads plus randomized loads
// with random stalls, checked against an array model of the table.
module tb_rom_loader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       busy;
  logic       done;
  logic [7:0] checksum;
  logic [3:0] wr_count;
  logic       enb;
  logic [2:0] addr;
  logic [7:0] out;

  always #5 clk = ~clk;

  rom_loader dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .busy     (busy),
    .done     (done),
    .checksum (checksum),
    .wr_count (wr_count),
    .enb      (enb),
    .addr     (addr),
    .out      (out)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: what each table entry should hold, and whether written.
  logic [7:0] ref_mem [8];
  bit         ref_wr  [8];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic read_check(input int a);
    if (ref_wr[a]) begin
      enb  = 1'b1;
      addr = 3'(a);
      tick();
      check($sformatf("read[%0d]", a), 32'(out), 32'(ref_mem[a]));
      enb  = 1'b0;
    end
  endtask

  // One full load of 8 bytes. Stalls: stall_len cycles before byte stall_at,
  // otherwise 0..max_stall random cycles. poke_start drives start high during
  // LOAD and DONE. rw_idx (<7, or -1) reads that address in its write cycle.
  task automatic do_load(input logic [7:0] b [8], input int max_stall,
                         input int stall_at, input int stall_len,
                         input bit poke_start, input int rw_idx);
    logic [7:0] sum;
    int         n;
    int         st;
    bit         rd_pending;
    sum        = 8'h00;
    n          = 0;
    rd_pending = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_busy", 32'(busy), 1);
    check("start_ready", 32'(in_ready), 1);
    check("start_cnt_clr", 32'(wr_count), 0);
    check("start_sum_clr", 32'(checksum), 0);
    while (n < 8) begin
      if (n == stall_at) st = stall_len;
      else if (max_stall > 0) st = $urandom_range(0, max_stall);
      else st = 0;
      repeat (st) begin
        in_valid = 1'b0;
        start    = poke_start;
        tick();
        check("stall_cnt", 32'(wr_count), 32'(n));
        check("stall_ready", 32'(in_ready), 1);
        if (rd_pending) begin
          check("rbw_new", 32'(out), 32'(b[rw_idx]));
          rd_pending = 1'b0;
          enb        = 1'b0;
        end
      end
      in_valid = 1'b1;
      in_data  = b[n];
      start    = poke_start;
      if (n == rw_idx) begin
        enb  = 1'b1;
        addr = 3'(n);
      end
      tick();
      if (rd_pending) begin
        check("rbw_new", 32'(out), 32'(b[rw_idx]));
        rd_pending = 1'b0;
        enb        = 1'b0;
      end
      if (n == rw_idx) begin
        check("rbw_old", 32'(out), 32'(ref_mem[n]));
        rd_pending = 1'b1;
      end
      ref_mem[n] = b[n];
      ref_wr[n]  = 1'b1;
      sum        = sum ^ b[n];
      n++;
      check("run_cnt", 32'(wr_count), 32'(n));
      check("run_sum", 32'(checksum), 32'(sum));
      if (n < 8) check("early_done", 32'(done), 0);
    end
    in_valid = 1'b0;
    start    = poke_start;
    check("done_pulse", 32'(done), 1);
    check("done_ready", 32'(in_ready), 0);
    check("done_busy", 32'(busy), 0);
    tick();
    start = 1'b0;
    check("done_once", 32'(done), 0);
    check("idle_busy", 32'(busy), 0);
    check("hold_cnt", 32'(wr_count), 8);
    check("hold_sum", 32'(checksum), 32'(sum));
    tick();
    check("still_idle", 32'(busy), 0);
    check("still_no_done", 32'(done), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] plan_a [8];
    logic [7:0] plan_c [8];
    logic [7:0] all_11 [8];
    logic [7:0] rnd    [8];
    logic [7:0] part   [4];

    plan_a = '{8'h01, 8'haa, 8'h54, 8'hfa, 8'he5, 8'h98, 8'h56, 8'h34};
    plan_c = '{8'h01, 8'haa, 8'h55, 8'hfa, 8'he5, 8'h98, 8'h56, 8'h34};
    all_11 = '{default: 8'h11};
    for (int i = 0; i < 8; i++) begin
      ref_mem[i] = 8'h00;
      ref_wr[i]  = 1'b0;
    end

    rst_n    = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    enb      = 1'b0;
    addr     = 3'd0;
    tick();
    tick();
    rst_n = 1'b1;
    repeat (5) tick();
    check("rst_ready", 32'(in_ready), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_out", 32'(out), 0);
    check("rst_sum", 32'(checksum), 0);
    check("rst_cnt", 32'(wr_count), 0);

    // Plain back-to-back load and two reads.
    do_load(plan_a, 0, -1, 0, 1'b0, -1);
    check("plan_sum", 32'(checksum), 32'h1a);
    read_check(3);
    check("plan_addr3", 32'(out), 32'hfa);
    read_check(7);
    check("plan_addr7", 32'(out), 32'h34);
    tick();
    check("out_disabled", 32'(out), 0);

    // Same load with a 3-cycle stall before the third byte.
    do_load(plan_a, 0, 2, 3, 1'b0, -1);
    check("stall_sum", 32'(checksum), 32'h1a);
    for (int i = 0; i < 8; i++) read_check(i);

    // Reset after four accepted bytes, then a full reload of 0x11.
    for (int i = 0; i < 4; i++) part[i] = 8'($urandom);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = part[i];
      tick();
      ref_mem[i] = part[i];
    end
    in_valid = 1'b0;
    rst_n    = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midrst_busy", 32'(busy), 0);
    check("midrst_ready", 32'(in_ready), 0);
    check("midrst_cnt", 32'(wr_count), 0);
    check("midrst_sum", 32'(checksum), 0);
    check("midrst_done", 32'(done), 0);
    tick();
    check("midrst_idle", 32'(busy), 0);
    for (int i = 0; i < 8; i++) read_check(i);
    do_load(all_11, 0, -1, 0, 1'b1, -1);
    check("reload_sum", 32'(checksum), 32'h00);
    for (int i = 0; i < 8; i++) begin
      read_check(i);
      check("reload_val", 32'(out), 32'h11);
    end

    // Read-before-write on address 2 while 0x55 replaces 0x54.
    do_load(plan_a, 0, -1, 0, 1'b0, -1);
    do_load(plan_c, 0, -1, 0, 1'b0, 2);
    read_check(2);

    // Randomized loads with random stalls and start pokes.
    for (int l = 0; l < 8; l++) begin
      for (int i = 0; i < 8; i++) rnd[i] = 8'($urandom);
      do_load(rnd, 3, -1, 0, 1'($urandom), int'($urandom_range(0, 7)) - 1);
      for (int k = 0; k < 4; k++) read_check(int'($urandom_range(0, 7)));
      tick();
      check("rnd_out_disabled", 32'(out), 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rom_loader.md
# rom_loader

Write-side companion to the team's 8x8 single-port ROM. It accepts a stream of 8 bytes over a valid/ready handshake and writes them in address order into an internal 8-entry x 8-bit array. The array keeps its contents after loading, so the block can serve as a programmable lookup table behind the same registered read port the ROM exposes. Each load produces a one-cycle completion pulse and an XOR checksum of the bytes written.

## Interface
Parameters:
- DATA_W, 8, width of each memory word and of the input byte
- ADDR_W, 3, address width
- DEPTH, 8, number of words; must equal 2**ADDR_W

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset: synchronous, active-low
- start  in  1  starts a load; sampled only in IDLE
- in_valid  in  1  in_data is valid this cycle
- in_data  in  DATA_W  byte to write
- in_ready  out  1  loader accepts a byte this cycle
- busy  out  1  high in LOAD
- done  out  1  one-cycle pulse, cycle after the final byte is accepted
- checksum  out  DATA_W  XOR of all bytes accepted in the current or most recent load
- wr_count  out  ADDR_W+1  number of bytes accepted in the current load, range 0..DEPTH
- enb  in  1  read enable
- addr  in  ADDR_W  read address
- out  out  DATA_W  registered read data

## Operation
- The FSM has three states: IDLE, LOAD and DONE.
- IDLE:
  - in_ready=0, busy=0.
  - When start=1, go to LOAD. On the same edge, clear the write pointer, wr_count and checksum to 0.
- LOAD:
  - in_ready=1, busy=1.
  - A transfer happens when in_valid and in_ready are both high.
  - On each transfer: mem[wr_ptr] <= in_data; checksum <= checksum ^ in_data; wr_ptr <= wr_ptr+1 (wraps naturally at ADDR_W bits); wr_count <= wr_count+1.
  - The transfer with wr_ptr == DEPTH-1 is the final byte and moves the FSM to DONE.
  - in_valid low means a stall: no state change, no limit on stall length.
- DONE:
  - done=1, in_ready=0, busy=0.
  - Unconditionally return to IDLE on the next cycle.
- start is ignored in LOAD and DONE. A new load can begin from IDLE no earlier than the cycle after the done pulse.
- checksum and wr_count hold their values in IDLE and DONE until the next start.
- Read port:
  - Works in every state, independent of the FSM.
  - enb=1: out <= mem[addr].
  - enb=0: out <= 0.
  - If a read and a write hit the same address in the same cycle, the read returns the old contents (read-before-write).
- Reset:
  - Affects state, wr_ptr, wr_count, checksum, out and done.
  - Does not affect mem contents. A reset in the middle of a load leaves the bytes already written in place and returns the FSM to IDLE.
  - Reading a location that has never been written returns undefined data; benches must not check it.

## Timing
- Reset values: state=IDLE, in_ready=0, busy=0, done=0, checksum=0, wr_count=0, out=0.
- From start high in IDLE to in_ready high: 1 cycle.
- Throughput in LOAD: 1 byte per cycle.
- Minimum load time: 8 cycles in LOAD.
- Write latency: a byte accepted at edge N is readable by a read issued at edge N+1, and appears on out after edge N+2.
- Read latency: 1 cycle from enb/addr to out.
- done is high for exactly one cycle, the cycle after the edge that accepted the final byte.
- in_ready and busy are decoded from state only, with no combinational path from in_valid.

## Structure
- Shared package rom_pkg holds:
  - constants DATA_W=8, ADDR_W=3, DEPTH=8;
  - an enum for the load FSM states: IDLE, LOAD, DONE.
- One natural sub-module, rom_store: the 8x8 array with a synchronous write port and a registered read port (enb/addr/out, 0 when disabled).
- rom_loader contains the FSM, the pointer, counter and checksum, and an instance of rom_store.

## Test plan
- Reset, then hold start=0 for 5 cycles -> in_ready=0, busy=0, done=0, out=0, checksum=0, wr_count=0.
- start, then bytes 01,aa,54,fa,e5,98,56,34 with in_valid held high -> done pulses for one cycle after the 8th accept; checksum=1a; wr_count=8. Then enb=1, addr=3 -> out=fa one cycle later; addr=7 -> out=34.
- Same load with in_valid low for 3 cycles between bytes 2 and 3 -> the same memory contents, checksum=1a, and done one cycle after the 8th accept.
- Assert rst_n=0 after 4 bytes, then reload with 8 bytes of 11 -> after the first reset: state IDLE, wr_count=0; after the reload: done pulses, checksum=00, addr 0..7 all read 11.
- Pulse start during LOAD and during DONE -> no effect: wr_count continues counting and done pulses exactly once.
- In the cycle that writes 55 to addr 2 (old value 54), read addr 2 -> out=54 one cycle later; read again on the next cycle -> out=55.
